// File: rtl/lc3b_types.sv
// -----------------------------------------------------------------------------
// lc3b_types
//   Shared LC-3b datapath types. Holds the base word type and the types used by
//   the write-combining buffer: 128-bit line, 8-bit word-valid mask, 12-bit
//   line tag, 3-bit word selector and the buffer state enum.
//   wcb_onehot() turns a word selector into its single-bit mask.
// -----------------------------------------------------------------------------
package lc3b_types;

    typedef logic [15:0]  lc3b_word;
    typedef logic [127:0] lc3b_line;
    typedef logic [7:0]   lc3b_wmask;
    typedef logic [11:0]  lc3b_line_tag;
    typedef logic [2:0]   lc3b_word_sel;

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        COLLECT = 2'd1,
        DRAIN   = 2'd2
    } wcb_state_t;

    localparam int LC3B_WORDS_PER_LINE = 8;

    function automatic lc3b_wmask wcb_onehot(input lc3b_word_sel sel);
        return lc3b_wmask'(8'h01 << sel);
    endfunction

endpackage

// File: rtl/write_combine_buffer_word_inserter.sv
// -----------------------------------------------------------------------------
// word_inserter
//   Replaces one 16-bit word of a 128-bit line, leaving the other seven words
//   untouched. Purely combinational.
//   Ports:
//     sel      in   3    word index within the line (word i = bits [16i+15:16i])
//     data     in   128  original line
//     new_word in   16   word to insert
//     out      out  128  line with word 'sel' replaced by new_word
// -----------------------------------------------------------------------------
module word_inserter
    import lc3b_types::*;
(
    input  lc3b_word_sel sel,
    input  lc3b_line     data,
    input  lc3b_word     new_word,
    output lc3b_line     out
);

    always_comb begin
        out = data;
        out[{sel, 4'b0000} +: 16] = new_word;
    end

endmodule

// File: rtl/write_combine_buffer.sv
// -----------------------------------------------------------------------------
// write_combine_buffer
//   Single-line write-combining buffer between the CPU data port and the
//   memory/cache write port. 16-bit stores to the same 128-bit line are merged
//   into a line register with a per-word valid mask. The line is written out as
//   one masked 128-bit write when a store to another line arrives, the line
//   fills, the buffer sits idle for TIMEOUT cycles, a load needs the line, or a
//   flush is requested.
//
//   Optional build macro:
//     WCB_READ_FORWARD_EN  loads that hit a valid buffered word are answered
//                          from the buffer (cpu_rhit/cpu_rdata) without a
//                          drain. Undefined: cpu_rhit/cpu_rdata stay 0 and any
//                          load to the buffered line stalls and forces a drain.
//
//   Parameter:
//     TIMEOUT      idle COLLECT cycles before an automatic drain (>= 2)
//
//   Ports:
//     clk          in   1    clock, rising edge
//     reset        in   1    asynchronous, active-high
//     cpu_write    in   1    store request, held until cpu_resp
//     cpu_address  in   16   byte address; tag = [15:4], word = [3:1]
//     cpu_wdata    in   16   store data
//     cpu_resp     out  1    one-cycle store acknowledge
//     cpu_read     in   1    load probe (address on cpu_address)
//     cpu_rhit     out  1    load answered from the buffer
//     cpu_rdata    out  16   forwarded word
//     cpu_rstall   out  1    load must wait while the buffer drains
//     flush        in   1    drain request, held until flush_done
//     flush_done   out  1    one-cycle flush acknowledge
//     mem_write    out  1    line write request
//     mem_address  out  16   {tag, 4'b0}
//     mem_wdata    out  128  merged line
//     mem_wmask    out  8    word-valid mask, bit i = word i
//     mem_resp     in   1    memory write complete
// -----------------------------------------------------------------------------
module write_combine_buffer
    import lc3b_types::*;
#(
    parameter int TIMEOUT = 32
)
(
    input  logic          clk,
    input  logic          reset,
    input  logic          cpu_write,
    input  logic [15:0]   cpu_address,
    input  logic [15:0]   cpu_wdata,
    output logic          cpu_resp,
    input  logic          cpu_read,
    output logic          cpu_rhit,
    output logic [15:0]   cpu_rdata,
    output logic          cpu_rstall,
    input  logic          flush,
    output logic          flush_done,
    output logic          mem_write,
    output logic [15:0]   mem_address,
    output logic [127:0]  mem_wdata,
    output logic [7:0]    mem_wmask,
    input  logic          mem_resp
);

    localparam int               CNT_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT - 1);

    wcb_state_t       state_q, state_d;
    lc3b_line_tag     tag_q, tag_d;
    lc3b_wmask        mask_q, mask_d;
    lc3b_line         line_q, line_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             resp_q, resp_d;
    logic             flush_lat_q, flush_lat_d;
    logic             flush_done_q, flush_done_d;

    lc3b_line_tag     req_tag;
    lc3b_word_sel     req_sel;
    logic             tag_hit;
    logic             fwd_hit;
    logic             store_req;
    logic             accept;
    logic             conflict;
    logic             flush_req;
    logic             timeout_hit;
    lc3b_line         merged_line;
    lc3b_wmask        merged_mask;

    assign req_tag = cpu_address[15:4];
    assign req_sel = cpu_address[3:1];

    // A buffered line exists only outside EMPTY; the tag register is stale there.
    assign tag_hit = (state_q != EMPTY) && (req_tag == tag_q);

`ifdef WCB_READ_FORWARD_EN
    assign fwd_hit   = tag_hit && mask_q[req_sel];
    assign cpu_rhit  = cpu_read && fwd_hit;
    assign cpu_rdata = cpu_rhit ? line_q[{req_sel, 4'b0000} +: 16] : 16'h0000;
`else
    assign fwd_hit   = 1'b0;
    assign cpu_rhit  = 1'b0;
    assign cpu_rdata = 16'h0000;
`endif

    assign cpu_rstall = cpu_read && tag_hit && !fwd_hit;

    // The store is still held high during its resp cycle; ignore it there so
    // it is neither merged twice nor mistaken for a conflicting store.
    assign store_req = cpu_write && !resp_q;
    assign accept    = store_req &&
                       ((state_q == EMPTY) ||
                        ((state_q == COLLECT) && (req_tag == tag_q)));
    assign conflict  = store_req && (state_q == COLLECT) && (req_tag != tag_q);

    // flush stays high through its acknowledge cycle and while the drain it
    // caused is in flight; only a fresh request is acted upon.
    assign flush_req = flush && !flush_done_q && !flush_lat_q;

    // A store in the expiry cycle wins: it clears the counter instead.
    assign timeout_hit = (cnt_q == CNT_MAX) && !accept;

    word_inserter u_word_inserter (
        .sel      (req_sel),
        .data     (line_q),
        .new_word (cpu_wdata),
        .out      (merged_line)
    );

    // The first store of a line starts a fresh mask.
    assign merged_mask = ((state_q == EMPTY) ? 8'h00 : mask_q) | wcb_onehot(req_sel);

    always_comb begin
        state_d      = state_q;
        tag_d        = tag_q;
        mask_d       = mask_q;
        line_d       = line_q;
        cnt_d        = cnt_q;
        resp_d       = accept;
        flush_lat_d  = flush_lat_q;
        flush_done_d = 1'b0;

        if (accept) begin
            line_d = merged_line;
            mask_d = merged_mask;
            cnt_d  = '0;
        end

        unique case (state_q)
            EMPTY: begin
                cnt_d = '0;
                if (accept) begin
                    tag_d = req_tag;
                    // Store merges first; a simultaneous flush then drains it.
                    if (flush_req) begin
                        flush_lat_d = 1'b1;
                        state_d     = DRAIN;
                    end else begin
                        state_d = COLLECT;
                    end
                end else if (flush_req) begin
                    flush_done_d = 1'b1;
                end
            end

            COLLECT: begin
                if (!accept && (cnt_q != CNT_MAX)) begin
                    cnt_d = cnt_q + 1'b1;
                end
                if (flush_req) begin
                    flush_lat_d = 1'b1;
                end
                if (flush_req || conflict || timeout_hit || cpu_rstall ||
                    (mask_d == 8'hFF)) begin
                    state_d = DRAIN;
                end
            end

            DRAIN: begin
                cnt_d = '0;
                if (flush_req) begin
                    flush_lat_d = 1'b1;
                end
                if (mem_resp) begin
                    state_d      = EMPTY;
                    mask_d       = 8'h00;
                    flush_done_d = flush_lat_q || flush_req;
                    flush_lat_d  = 1'b0;
                end
            end

            default: begin
                state_d = EMPTY;
                mask_d  = 8'h00;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= EMPTY;
            tag_q        <= '0;
            mask_q       <= '0;
            line_q       <= '0;
            cnt_q        <= '0;
            resp_q       <= 1'b0;
            flush_lat_q  <= 1'b0;
            flush_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            tag_q        <= tag_d;
            mask_q       <= mask_d;
            line_q       <= line_d;
            cnt_q        <= cnt_d;
            resp_q       <= resp_d;
            flush_lat_q  <= flush_lat_d;
            flush_done_q <= flush_done_d;
        end
    end

    assign cpu_resp    = resp_q;
    assign flush_done  = flush_done_q;
    assign mem_write   = (state_q == DRAIN);
    assign mem_address = {tag_q, 4'b0000};
    assign mem_wdata   = line_q;
    assign mem_wmask   = mask_q;

endmodule

// File: tb/tb_write_combine_buffer.sv
// -----------------------------------------------------------------------------
// tb_write_combine_buffer
//   Directed scenarios followed by randomized stores, flushes, loads and idle
//   gaps. A behavioural model of the buffer (word array + valid flags + phase)
//   is compared against the DUT on every falling clock edge.
// -----------------------------------------------------------------------------
module tb_write_combine_buffer;

    localparam int TIMEOUT = 32;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         cpu_write = 1'b0;
    logic [15:0]  cpu_address = 16'h0000;
    logic [15:0]  cpu_wdata = 16'h0000;
    logic         cpu_read = 1'b0;
    logic         flush = 1'b0;
    logic         mem_resp = 1'b0;
    logic         cpu_resp;
    logic         cpu_rhit;
    logic [15:0]  cpu_rdata;
    logic         cpu_rstall;
    logic         flush_done;
    logic         mem_write;
    logic [15:0]  mem_address;
    logic [127:0] mem_wdata;
    logic [7:0]   mem_wmask;

    always #5 clk = ~clk;

    write_combine_buffer #(.TIMEOUT(TIMEOUT)) dut (
        .clk         (clk),
        .reset       (reset),
        .cpu_write   (cpu_write),
        .cpu_address (cpu_address),
        .cpu_wdata   (cpu_wdata),
        .cpu_resp    (cpu_resp),
        .cpu_read    (cpu_read),
        .cpu_rhit    (cpu_rhit),
        .cpu_rdata   (cpu_rdata),
        .cpu_rstall  (cpu_rstall),
        .flush       (flush),
        .flush_done  (flush_done),
        .mem_write   (mem_write),
        .mem_address (mem_address),
        .mem_wdata   (mem_wdata),
        .mem_wmask   (mem_wmask),
        .mem_resp    (mem_resp)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

`ifdef WCB_READ_FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Behavioural model: phase 0 = no line held, 1 = gathering, 2 = writing out
    // ------------------------------------------------------------------
    int          m_phase = 0;
    int          m_tag = 0;
    logic [15:0] m_words [8];
    bit          m_valid [8];
    int          m_idle = 0;
    bit          m_resp = 0;
    bit          m_fdone = 0;
    bit          m_fpend = 0;

    int          e_tag, e_idx;
    bit          e_match, e_fwd, e_rhit, e_rstall, e_acc, e_fl, e_go, e_full, e_nfd;
    logic [15:0] e_rdata;
    logic [7:0]  e_mask;

    always @(negedge clk) begin
        if (reset) begin
            m_phase = 0; m_tag = 0; m_idle = 0;
            m_resp = 0; m_fdone = 0; m_fpend = 0;
            for (int i = 0; i < 8; i++) begin m_valid[i] = 0; m_words[i] = 16'h0; end
        end
        e_tag   = int'(cpu_address[15:4]);
        e_idx   = int'(cpu_address[3:1]);
        e_match = (m_phase != 0) && (e_tag == m_tag);
        e_fwd   = FWD && e_match && m_valid[e_idx];
        e_rhit  = cpu_read && e_fwd;
        e_rdata = e_rhit ? m_words[e_idx] : 16'h0000;
        e_rstall = cpu_read && e_match && !e_fwd;
        e_mask  = 8'h00;
        for (int i = 0; i < 8; i++) e_mask[i] = m_valid[i];

        check("resp", cpu_resp, m_resp);
        check("mem_write", mem_write, m_phase == 2);
        check("flush_done", flush_done, m_fdone);
        check("rstall", cpu_rstall, e_rstall);
        check("rhit", cpu_rhit, e_rhit);
        check("rdata", cpu_rdata, e_rdata);
        if (m_phase == 2) begin
            check("mem_address", mem_address, 16'(m_tag << 4));
            check("mem_wmask", mem_wmask, e_mask);
            for (int i = 0; i < 8; i++)
                if (m_valid[i]) check("mem_word", mem_wdata[i*16 +: 16], m_words[i]);
        end

        if (!reset) begin
            e_acc = cpu_write && !m_resp && (m_phase == 0 || (m_phase == 1 && e_tag == m_tag));
            e_fl  = flush && !m_fdone && !m_fpend;
            e_nfd = 0;
            case (m_phase)
                0: begin
                    if (e_acc) begin
                        for (int i = 0; i < 8; i++) m_valid[i] = 0;
                        m_tag = e_tag; m_valid[e_idx] = 1; m_words[e_idx] = cpu_wdata; m_idle = 0;
                        if (e_fl) begin m_fpend = 1; m_phase = 2; end
                        else m_phase = 1;
                    end else if (e_fl) e_nfd = 1;
                end
                1: begin
                    e_go = e_fl || e_rstall || (cpu_write && !m_resp && e_tag != m_tag) ||
                           (!e_acc && m_idle == TIMEOUT - 1);
                    if (e_acc) begin
                        m_valid[e_idx] = 1; m_words[e_idx] = cpu_wdata; m_idle = 0;
                    end else if (m_idle < TIMEOUT - 1) m_idle++;
                    e_full = 1;
                    for (int i = 0; i < 8; i++) if (!m_valid[i]) e_full = 0;
                    if (e_full) e_go = 1;
                    if (e_fl) m_fpend = 1;
                    if (e_go) m_phase = 2;
                end
                default: begin
                    if (e_fl) m_fpend = 1;
                    if (mem_resp) begin
                        m_phase = 0; m_idle = 0;
                        for (int i = 0; i < 8; i++) m_valid[i] = 0;
                        e_nfd = m_fpend; m_fpend = 0;
                    end
                end
            endcase
            m_resp  = e_acc;
            m_fdone = e_nfd;
        end
    end

    // ------------------------------------------------------------------
    // Memory responder: answers a write after 0..3 cycles unless held off
    // ------------------------------------------------------------------
    bit mem_hold = 0;
    int rsp_dly  = 0;
    initial begin
        forever begin
            @(posedge clk); #1;
            if (mem_resp || reset) mem_resp = 1'b0;
            else if (mem_write && !mem_hold) begin
                if (rsp_dly == 0) begin
                    mem_resp = 1'b1;
                    rsp_dly  = $urandom_range(0, 3);
                end else rsp_dly--;
            end
        end
    end

    initial begin
        #800000;
        $display("FAIL watchdog expired checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------
    // Driver tasks (entered and left just after a rising edge)
    // ------------------------------------------------------------------
    bit          mw_at_resp;
    logic [7:0]  mask_at_resp;
    bit          f_saw_mw;
    logic [7:0]  f_mask;
    logic [15:0] f_addr;
    logic [15:0] f_word0;

    task automatic do_store(input logic [15:0] a, input logic [15:0] d, output int lat);
        cpu_write = 1'b1; cpu_address = a; cpu_wdata = d; lat = 0;
        do begin @(negedge clk); lat++; end while (!cpu_resp && lat < 300);
        check("store_ack_seen", cpu_resp, 1'b1);
        mw_at_resp = mem_write; mask_at_resp = mem_wmask;
        @(posedge clk); #1; cpu_write = 1'b0;
    endtask

    task automatic do_flush(output int lat, output int resp_to_done);
        int rc;
        rc = -100; lat = 0; f_saw_mw = 0;
        flush = 1'b1;
        do begin
            @(negedge clk); lat++;
            if (mem_write && !f_saw_mw) begin
                f_saw_mw = 1; f_mask = mem_wmask; f_addr = mem_address; f_word0 = mem_wdata[15:0];
            end
            if (mem_resp) rc = lat;
        end while (!flush_done && lat < 300);
        check("flush_ack_seen", flush_done, 1'b1);
        resp_to_done = lat - rc;
        @(posedge clk); #1; flush = 1'b0;
    endtask

    task automatic wait_drained();
        int k;
        k = 0;
        do begin @(negedge clk); k++; end while (mem_write && k < 300);
        check("drain_ends", mem_write, 1'b0);
        @(posedge clk); #1;
    endtask

    // ------------------------------------------------------------------
    // Directed scenarios, then random traffic
    // ------------------------------------------------------------------
    initial begin
        int lat, k, rtd;
        logic [15:0] a;

        #1 reset = 1'b1;
        @(negedge clk);
        check("rst_resp", cpu_resp, 1'b0);
        check("rst_mem_write", mem_write, 1'b0);
        check("rst_mask", mem_wmask, 8'h00);
        check("rst_addr", mem_address, 16'h0000);
        check("rst_wdata", mem_wdata, 128'h0);
        check("rst_flush_done", flush_done, 1'b0);
        check("rst_rstall", cpu_rstall, 1'b0);
        @(posedge clk); #1 reset = 1'b0;

        // Two stores, then idle timeout
        do_store(16'h4000, 16'h1111, lat); check("t1_lat_a", lat, 2);
        do_store(16'h4002, 16'h2222, lat); check("t1_lat_b", lat, 2);
        k = 0;
        do begin @(negedge clk); k++; end while (!mem_write && k < 100);
        check("t1_idle_cycles", k, TIMEOUT);
        check("t1_addr", mem_address, 16'h4000);
        check("t1_mask", mem_wmask, 8'h03);
        check("t1_data", mem_wdata[31:0], 32'h22221111);
        @(posedge clk); #1;
        wait_drained();

        // Eight stores fill the line
        for (int i = 0; i < 8; i++) begin
            do_store(16'h6000 + 16'(2 * i), 16'hA000 + 16'(i), lat);
            check("t2_lat", lat, 2);
        end
        check("t2_drain_after_8th", mw_at_resp, 1'b1);
        check("t2_full_mask", mask_at_resp, 8'hFF);
        wait_drained();

        // Conflicting store waits for the drain of the held line
        do_store(16'h4000, 16'h3333, lat);
        mem_hold = 1;
        cpu_write = 1'b1; cpu_address = 16'h5000; cpu_wdata = 16'h5555;
        repeat (2) @(negedge clk);
        check("t3_no_ack", cpu_resp, 1'b0);
        check("t3_draining", mem_write, 1'b1);
        check("t3_addr", mem_address, 16'h4000);
        check("t3_mask", mem_wmask, 8'h01);
        check("t3_word", mem_wdata[15:0], 16'h3333);
        @(posedge clk); #1; mem_hold = 0;
        k = 0;
        do begin @(negedge clk); k++; end while (!cpu_resp && k < 100);
        check("t3_late_ack", cpu_resp, 1'b1);
        @(posedge clk); #1; cpu_write = 1'b0;

        // Flush while gathering, then flush while empty
        do_flush(lat, rtd);
        check("t4_flush_drained", f_saw_mw, 1'b1);
        check("t4_new_line_addr", f_addr, 16'h5000);
        check("t4_new_line_mask", f_mask, 8'h01);
        check("t4_new_line_word", f_word0, 16'h5555);
        check("t4_done_after_resp", rtd, 1);
        do_flush(lat, rtd);
        check("t4_empty_flush_lat", lat, 2);
        check("t4_empty_no_write", f_saw_mw, 1'b0);

        // Loads against a held line
        do_store(16'h4000, 16'h1111, lat);
        mem_hold = 1;
        cpu_read = 1'b1; cpu_address = 16'h4000;
        @(negedge clk);
        check("t5_valid_rhit", cpu_rhit, FWD);
        check("t5_valid_rdata", cpu_rdata, FWD ? 16'h1111 : 16'h0000);
        check("t5_valid_rstall", cpu_rstall, !FWD);
        @(posedge clk); #1; cpu_address = 16'h4004;
        @(negedge clk);
        check("t5_invalid_rstall", cpu_rstall, 1'b1);
        check("t5_invalid_rhit", cpu_rhit, 1'b0);
        @(posedge clk); #1; mem_hold = 0;
        k = 0;
        do begin @(negedge clk); k++; end while (cpu_rstall && k < 100);
        check("t5_stall_released", cpu_rstall, 1'b0);
        check("t5_line_gone", mem_write, 1'b0);
        @(posedge clk); #1; cpu_read = 1'b0;

        // Reset in the middle of a drain
        do_store(16'h7000, 16'h7777, lat);
        mem_hold = 1;
        cpu_read = 1'b1; cpu_address = 16'h7002;
        @(posedge clk); #1; cpu_read = 1'b0;
        @(negedge clk);
        check("t6_draining", mem_write, 1'b1);
        @(posedge clk); #1; reset = 1'b1;
        #1;
        check("t6_write_drops", mem_write, 1'b0);
        check("t6_mask_cleared", mem_wmask, 8'h00);
        @(negedge clk); #2; reset = 1'b0; mem_hold = 0;
        @(posedge clk); #1;
        do_store(16'h7004, 16'h4444, lat); check("t6_fresh_lat", lat, 2);
        do_flush(lat, rtd);
        check("t6_fresh_mask", f_mask, 8'h04);
        check("t6_fresh_addr", f_addr, 16'h7000);

        // Random traffic
        for (int it = 0; it < 600; it++) begin
            k = $urandom_range(0, 9);
            a = 16'h4000 + 16'($urandom_range(0, 2) << 4) +
                16'($urandom_range(0, 7) << 1) + 16'($urandom_range(0, 1));
            if (k <= 5) begin
                do_store(a, 16'($urandom), lat);
            end else if (k == 6) begin
                do_flush(lat, rtd);
            end else if (k <= 8) begin
                cpu_read = 1'b1; cpu_address = a;
                repeat ($urandom_range(1, 3)) begin @(posedge clk); #1; end
                cpu_read = 1'b0;
            end else begin
                repeat ($urandom_range(1, 40)) begin @(posedge clk); #1; end
            end
        end
        do_flush(lat, rtd);
        repeat (4) @(posedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
